cdc_hs_src: RTL and testbench

- Source-domain sender of a 4-phase req/ack handshake that moves a multi-bit word across a clock boundary.
- Captures a word on a valid/ready handshake and holds it stable on o_data.
- Raises a level request that the destination side synchronizes with cdc_sync. Waits for the returned acknowledge, which arrives through a cdc_sync instance in this block's clock domain.
- Reports completion and watchdog timeouts; sits directly upstream of the destination-side cdc_sync.

---
 rtl/cdc_hs_src.sv | 139 +++++++++++++
 tb/tb_cdc_hs_src.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_src.sv
// rtl/cdc_hs_src.sv - source side of a 4-phase req/ack handshake carrying a word across clock domains
//
// Holds the accepted word on o_data for the whole handshake and drives a registered
// request level. The acknowledge comes back already synchronized into clk. A per-phase
// watchdog flags a phase that is taking too long, but it never aborts the handshake.
module cdc_hs_src #(
    parameter int DATA_W    = 8,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_req,
    input  logic              i_ack_sync,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    // Wide enough to hold TO_CYCLES itself, which is the saturation value.
    localparam int CNT_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              ready;
    logic              accept;
    logic              done;
    logic              to_q;

    // State and registered outputs; the async reset drops o_req and clears o_data at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: IDLE -> REQ on acceptance, REQ -> REL on ack high, REL -> IDLE on ack low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ack_sync) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!i_ack_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: ready blocks on a stale ack in IDLE; req/busy are registered from next state.
    always_comb begin
        ready  = (state_q == ST_IDLE) && !i_ack_sync;
        accept = ready && i_valid;
        done   = (state_q == ST_REL) && !i_ack_sync;
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d != ST_IDLE);
        data_d = data_q;
        if (accept) begin
            data_d = i_data;
        end
    end

    generate
        if (TO_CYCLES > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);
            localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TO_CYCLES);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             to_d;

            // Watchdog counter and timeout pulse register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    to_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    to_q  <= to_d;
                end
            end

            // Count cycles spent in the current phase; restart on any state change and
            // stop at TO_CYCLES so the one-shot compare cannot match twice in a phase.
            always_comb begin
                cnt_d = cnt_q;
                to_d  = 1'b0;
                if (state_d != state_q) begin
                    cnt_d = '0;
                end else if ((state_q != ST_IDLE) && (cnt_q != TO_SAT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((state_q != ST_IDLE) && (cnt_q == TO_LAST)) begin
                    to_d = 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign to_q = 1'b0;
        end
    endgenerate

    assign o_ready   = ready;
    assign o_data    = data_q;
    assign o_req     = req_q;
    assign o_busy    = busy_q;
    assign o_done    = done;
    assign o_timeout = to_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// tb/tb_cdc_hs_src.sv - bench for cdc_hs_src with a transaction-level reference model
module tb_cdc_hs_src;

    localparam int TO_A = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_ack_sync;

    logic       a_ready, a_req, a_busy, a_done, a_to;
    logic [7:0] a_data;
    logic       b_ready, b_req, b_busy, b_done, b_to;
    logic [7:0] b_data;

    cdc_hs_src #(.DATA_W(8), .TO_CYCLES(TO_A)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(a_ready), .o_data(a_data), .o_req(a_req), .i_ack_sync(i_ack_sync),
        .o_busy(a_busy), .o_done(a_done), .o_timeout(a_to)
    );

    cdc_hs_src #(.DATA_W(8), .TO_CYCLES(0)) dut_nowd (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(b_ready), .o_data(b_data), .o_req(b_req), .i_ack_sync(i_ack_sync),
        .o_busy(b_busy), .o_done(b_done), .o_timeout(b_to)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase 0 = waiting for a word, 1 = requesting, 2 = releasing.
    int         ph = 0;
    int         age = 0;
    logic [7:0] held = 8'h00;
    logic       to_pend = 1'b0;
    logic       took = 1'b0;

    logic [7:0] src_q[$];
    int         dones_seen = 0;
    int         a_to_seen = 0;
    int         b_to_seen = 0;

    int ack_mode = 0;
    int ack_dly = 2;
    int ack_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        if (ph != 0 && src_q.size() > 0) void'(src_q.pop_back());
        ph = 0; age = 0; held = 8'h00; to_pend = 1'b0;
    endtask

    task automatic check_all();
        logic e_ready, e_done;
        e_ready = (ph == 0) && !i_ack_sync;
        e_done  = (ph == 2) && !i_ack_sync;
        chk("ready",   a_ready, e_ready);
        chk("req",     a_req,   ph == 1);
        chk("busy",    a_busy,  ph != 0);
        chk("data",    a_data,  held);
        chk("done",    a_done,  e_done);
        chk("timeout", a_to,    to_pend);
        chk("nw_ready", b_ready, e_ready);
        chk("nw_req",   b_req,   ph == 1);
        chk("nw_data",  b_data,  held);
        chk("nw_done",  b_done,  e_done);
        chk("nw_timeout", b_to,  1'b0);
    endtask

    // One clock: called just after a falling edge with i_valid/i_data already set.
    task automatic tick();
        logic nxt_to;
        logic tgt;
        if (ack_mode == 1) i_ack_sync = 1'b0;
        else if (ack_mode == 2) i_ack_sync = 1'b1;
        else begin
            tgt = (ph == 1);
            if (i_ack_sync != tgt) begin
                if (ack_cnt >= ack_dly) begin
                    i_ack_sync = tgt;
                    ack_cnt = 0;
                    ack_dly = $urandom_range(0, 4);
                end else ack_cnt++;
            end else ack_cnt = 0;
        end
        #1;
        check_all();
        if (a_to) a_to_seen++;
        if (b_to) b_to_seen++;
        if (a_done) begin
            dones_seen++;
            chk("sb_nonempty", src_q.size() != 0, 1'b1);
            if (src_q.size() != 0) chk("sb_word", a_data, src_q.pop_front());
        end
        @(posedge clk);
        nxt_to = (ph != 0) && (age == TO_A - 1);
        if (ph == 0) begin
            if (i_valid && !i_ack_sync) begin
                held = i_data; ph = 1; age = 0; took = 1'b1;
            end
        end else if (ph == 1) begin
            if (i_ack_sync) begin ph = 2; age = 0; end
            else age++;
        end else begin
            if (!i_ack_sync) begin ph = 0; age = 0; end
            else age++;
        end
        to_pend = nxt_to;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w, input bit keep);
        i_data = w;
        i_valid = 1'b1;
        src_q.push_back(w);
        took = 1'b0;
        for (int k = 0; k < 200 && !took; k++) tick();
        chk("accept", took, 1'b1);
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        for (int k = 0; k < n && ph != 0; k++) tick();
        chk("wait_idle", ph, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_ack_sync = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single transfer with a fixed two-cycle acknowledge delay.
        ack_dly = 2; ack_cnt = 0;
        d0 = dones_seen;
        send(8'hA5, 1'b0);
        wait_idle(50);
        tick();
        chk("single_done", dones_seen - d0, 1);

        // Back-to-back with valid held high.
        d0 = dones_seen;
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b0);
        wait_idle(50);
        chk("b2b_done", dones_seen - d0, 3);

        // Words offered while not ready must be ignored.
        send(8'h3C, 1'b0);
        while (ph != 0) begin
            i_valid = (ph != 0);
            i_data = 8'hFF;
            tick();
        end
        i_valid = 1'b0;
        tick();
        chk("notready_held", a_data, 8'h3C);

        // Randomized traffic with random gaps and acknowledge delays.
        for (int t = 0; t < 40; t++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            send(8'($urandom), $urandom_range(0, 1) == 1);
        end
        i_valid = 1'b0;
        wait_idle(50);

        // Watchdog: ack withheld well past the limit, then supplied.
        a_to_seen = 0;
        d0 = dones_seen;
        ack_mode = 1;
        send(8'h77, 1'b0);
        for (int k = 0; k < 30; k++) tick();
        chk("to_once", a_to_seen, 1);
        chk("to_req_held", a_req, 1'b1);
        ack_mode = 0;
        wait_idle(50);
        chk("to_done", dones_seen - d0, 1);

        // Reset while requesting with ack high.
        ack_mode = 1;
        send(8'h99, 1'b0);
        tick();
        ack_mode = 2;
        i_ack_sync = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        d0 = dones_seen;
        i_valid = 1'b1; i_data = 8'h5A;
        for (int k = 0; k < 5; k++) tick();
        chk("stale_no_done", dones_seen - d0, 0);
        ack_mode = 0;
        src_q.push_back(8'h5A);
        took = 1'b0;
        for (int k = 0; k < 50 && !took; k++) tick();
        chk("stale_accept", took, 1'b1);
        i_valid = 1'b0;
        wait_idle(50);

        // Long withheld ack: only the watchdog-enabled instance may flag it.
        a_to_seen = 0; b_to_seen = 0;
        ack_mode = 1;
        send(8'hC3, 1'b0);
        for (int k = 0; k < 5000; k++) tick();
        chk("long_to_a", a_to_seen, 1);
        chk("long_to_b", b_to_seen, 0);
        ack_mode = 0;
        wait_idle(50);
        tick();
        chk("sb_drained", src_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
